// File: rtl/cache_miss_controller.sv
// cache_miss_controller
//   Sequences miss handling for a two-way cache. On a miss it stalls the CPU
//   and writes back the evicted word if it is dirty. It then fetches the
//   missed word from RAM and strobes after_miss so the cache replays the
//   access. This block owns the single RAM port.
//
//   Optional feature macro: PERF_COUNTERS_EN. When it is defined, the block
//   adds the saturating miss_count and wb_count outputs.
//
// Ports
//   clk, rst          clock (rising edge), async active-high reset
//   en, cache_miss    CPU access valid / lookup missed (sampled in IDLE only)
//   addr              CPU access address
//   evict_we          evicted word is dirty and must be written back
//   evict_addr/data   evicted word address and data
//   stall             freezes the CPU pipeline
//   after_miss        one-cycle replay strobe to the cache
//   rd_from_ram       fetched word, held until the next fill completes
//   ram_req/we/addr/wd  registered RAM request
//   ram_rd, ram_ready   RAM read data / completion
//   o_state_dbg       current FSM state, for observation only
//   miss_count, wb_count  (PERF_COUNTERS_EN) serviced misses / writebacks
//
// RAM handshake: ram_req is held high together with stable ram_we, ram_addr
// and ram_wd until the RAM answers with ram_ready in the same cycle. When
// ram_req is low, ram_ready is ignored. A writeback that is followed by a fill
// keeps ram_req high and only switches ram_we and ram_addr.
module cache_miss_controller #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 32,
   parameter int CNT_WIDTH  = 16
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  en,
   input  logic                  cache_miss,
   input  logic [ADDR_WIDTH-1:0] addr,
   input  logic                  evict_we,
   input  logic [ADDR_WIDTH-1:0] evict_addr,
   input  logic [DATA_WIDTH-1:0] evict_data,
   output logic                  stall,
   output logic                  after_miss,
   output logic [DATA_WIDTH-1:0] rd_from_ram,
   output logic                  ram_req,
   output logic                  ram_we,
   output logic [ADDR_WIDTH-1:0] ram_addr,
   output logic [DATA_WIDTH-1:0] ram_wd,
   input  logic [DATA_WIDTH-1:0] ram_rd,
   input  logic                  ram_ready,
   output logic [1:0]            o_state_dbg
`ifdef PERF_COUNTERS_EN
   ,
   output logic [CNT_WIDTH-1:0]  miss_count,
   output logic [CNT_WIDTH-1:0]  wb_count
`endif
);

   typedef enum logic [1:0] {
      S_IDLE      = 2'd0,
      S_WRITEBACK = 2'd1,
      S_FILL      = 2'd2,
      S_REPLAY    = 2'd3
   } state_t;

   localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = {{(ADDR_WIDTH-2){1'b1}}, 2'b00};

   state_t                r_state;
   logic [ADDR_WIDTH-1:0] r_addr;
   logic                  w_start;

   assign w_start     = en & cache_miss & (r_state == S_IDLE);
   assign o_state_dbg = r_state;

   // In IDLE the stall must be raised in the same cycle as the miss, so it
   // cannot be registered. It is gated by rst so that reset clears it at once.
   assign stall = ~rst & ((r_state != S_IDLE) | (en & cache_miss));

`ifdef PERF_COUNTERS_EN
   localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         miss_count <= '0;
         wb_count   <= '0;
      end else begin
         if (w_start && (miss_count != '1))
            miss_count <= miss_count + CNT_ONE;
         if ((r_state == S_WRITEBACK) && ram_ready && (wb_count != '1))
            wb_count <= wb_count + CNT_ONE;
      end
   end
`else
   logic [CNT_WIDTH-1:0] w_unused_cnt;
   assign w_unused_cnt = '0;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state     <= S_IDLE;
         r_addr      <= '0;
         after_miss  <= 1'b0;
         rd_from_ram <= '0;
         ram_req     <= 1'b0;
         ram_we      <= 1'b0;
         ram_addr    <= '0;
         ram_wd      <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               after_miss <= 1'b0;
               if (w_start) begin
                  r_addr  <= addr & ALIGN_MASK;
                  ram_req <= 1'b1;
                  if (evict_we) begin
                     r_state  <= S_WRITEBACK;
                     ram_we   <= 1'b1;
                     ram_addr <= evict_addr & ALIGN_MASK;
                     ram_wd   <= evict_data;
                  end else begin
                     r_state  <= S_FILL;
                     ram_we   <= 1'b0;
                     ram_addr <= addr & ALIGN_MASK;
                  end
               end
            end
            S_WRITEBACK: begin
               // Move straight on to the fill: ram_req stays high.
               if (ram_ready) begin
                  r_state  <= S_FILL;
                  ram_we   <= 1'b0;
                  ram_addr <= r_addr;
               end
            end
            S_FILL: begin
               if (ram_ready) begin
                  rd_from_ram <= ram_rd;
                  ram_req     <= 1'b0;
                  ram_we      <= 1'b0;
                  after_miss  <= 1'b1;
                  r_state     <= S_REPLAY;
               end
            end
            S_REPLAY: begin
               after_miss <= 1'b0;
               r_state    <= S_IDLE;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_cache_miss_controller.sv
module tb_cache_miss_controller;

  localparam int DW = 32;
  localparam int AW = 32;
`ifdef PERF_COUNTERS_EN
  localparam int CW = 4;
`else
  localparam int CW = 16;
`endif

  // clock / reset block
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic          en = 1'b0, cache_miss = 1'b0, evict_we = 1'b0, ram_ready = 1'b0;
  logic [AW-1:0] addr = '0, evict_addr = '0;
  logic [DW-1:0] evict_data = '0, ram_rd = '0;
  logic          stall, after_miss, ram_req, ram_we;
  logic [DW-1:0] rd_from_ram, ram_wd;
  logic [AW-1:0] ram_addr;
  logic [1:0]    state_dbg;
`ifdef PERF_COUNTERS_EN
  logic [CW-1:0] miss_count, wb_count;
`endif

  cache_miss_controller #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .CNT_WIDTH(CW)) dut (
    .clk(clk), .rst(rst), .en(en), .cache_miss(cache_miss), .addr(addr),
    .evict_we(evict_we), .evict_addr(evict_addr), .evict_data(evict_data),
    .stall(stall), .after_miss(after_miss), .rd_from_ram(rd_from_ram),
    .ram_req(ram_req), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wd(ram_wd),
    .ram_rd(ram_rd), .ram_ready(ram_ready), .o_state_dbg(state_dbg)
`ifdef PERF_COUNTERS_EN
    , .miss_count(miss_count), .wb_count(wb_count)
`endif
  );

  // scoreboard: expected RAM transactions {we, addr, wd} and fetched words
  logic [64:0]   exp_q[$];
  logic [DW-1:0] exp_rd_q[$];
  logic [DW-1:0] last_rd = '0;
  int n_checks = 0;
  int n_errors = 0;
  int model_miss = 0;
  int model_wb = 0;

  typedef struct {
    logic [AW-1:0] addr;
    logic          ewe;
    logic [AW-1:0] eaddr;
    logic [DW-1:0] edata;
    logic [DW-1:0] rdata;
    int            wb_wait;
    int            fill_wait;
    bit            b2b;
    int            exp_stall;
  } vec_t;

  vec_t vecs[6];

  task automatic check(input string name, input logic [64:0] act, input logic [64:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Idle cycles: en low with random cache_miss and spurious ram_ready.
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      en = 1'b0;
      cache_miss = 1'($urandom_range(0, 1));
      addr = $urandom();
      #1;
      check("idle_stall", stall, 1'b0);
      check("idle_ram_req", ram_req, 1'b0);
      check("idle_rd_hold", rd_from_ram, last_rd);
      ram_ready = 1'($urandom_range(0, 1));
      @(negedge clk);
    end
    ram_ready = 1'b0;
  endtask

  // Drives one miss starting in the current low phase. It acts as the RAM
  // and returns in the first IDLE cycle after REPLAY, with that cycle's
  // inputs not yet sampled, so a following call forms a back-to-back miss.
  task automatic run_miss(input vec_t v);
    int stalls = 0, pulses = 0, waitleft = 0, cyc;
    bit in_req = 0, hold = 0, started = 0, after_prev;
    logic prev_we = 1'b0;
    logic [AW-1:0] prev_addr = '0;
    logic [DW-1:0] prev_wd = '0;
    logic [64:0] e;
    en = 1'b1; cache_miss = 1'b1; addr = v.addr; evict_we = v.ewe;
    evict_addr = v.eaddr; evict_data = v.edata;
    if (v.ewe) exp_q.push_back({1'b1, v.eaddr & ~32'h3, v.edata});
    exp_q.push_back({1'b0, v.addr & ~32'h3, 32'h0});
    exp_rd_q.push_back(v.rdata);
    model_miss++;
    if (v.ewe) model_wb++;
    for (cyc = 0; cyc < 60; cyc++) begin
      #1;
      if (cyc == 0) check("stall_on_miss", stall, 1'b1);
      if (cyc > 0 && !stall) break;
      if (stall) stalls++;
      if (after_miss) begin
        pulses++;
        if (exp_rd_q.size() > 0) begin
          last_rd = exp_rd_q.pop_front();
          check("rd_from_ram", rd_from_ram, last_rd);
        end
      end
      if (started) check("req_continuity", ram_req, exp_q.size() != 0);
      if (ram_req) begin
        started = 1;
        if (hold) begin
          check("hold_we", ram_we, prev_we);
          check("hold_addr", ram_addr, prev_addr);
          check("hold_wd", ram_wd, prev_wd);
        end
        if (!in_req) begin
          in_req = 1;
          waitleft = ram_we ? v.wb_wait : v.fill_wait;
        end
        prev_we = ram_we; prev_addr = ram_addr; prev_wd = ram_wd;
        if (waitleft == 0) begin
          ram_ready = 1'b1;
          ram_rd = ram_we ? $urandom() : v.rdata;
          in_req = 0; hold = 0;
          if (exp_q.size() == 0) begin
            check("unexpected_req", ram_req, 1'b0);
          end else begin
            e = exp_q.pop_front();
            check("ram_we", ram_we, e[64]);
            check("ram_addr", ram_addr, e[63:32]);
            if (e[64]) check("ram_wd", ram_wd, e[31:0]);
          end
        end else begin
          waitleft--;
          ram_ready = 1'b0;
          ram_rd = $urandom();
          hold = 1;
        end
      end else begin
        ram_ready = 1'($urandom_range(0, 1));
        ram_rd = $urandom();
        hold = 0;
      end
      after_prev = after_miss;
      @(negedge clk);
      if (after_prev) begin
        en = 1'b0;
        cache_miss = 1'($urandom_range(0, 1));
      end else begin
        // Inputs outside IDLE must be ignored.
        en = 1'($urandom_range(0, 1));
        cache_miss = 1'($urandom_range(0, 1));
        addr = $urandom(); evict_we = 1'($urandom_range(0, 1));
        evict_addr = $urandom(); evict_data = $urandom();
      end
    end
    ram_ready = 1'b0;
    check("miss_timeout", cyc >= 60, 1'b0);
    check("stall_cycles", stalls, v.exp_stall);
    check("after_miss_pulses", pulses, 1);
    check("queue_drained", exp_q.size(), 0);
  endtask

  function automatic int sat(input int x);
    return (x > (1 << CW) - 1) ? (1 << CW) - 1 : x;
  endfunction

  initial begin
    vec_t v;
    vecs[0] = '{32'h0000_0804, 1'b0, 32'h0, 32'h0, 32'hDEAD_BEEF, 0, 0, 1'b0, 3};
    vecs[1] = '{32'h0000_0807, 1'b1, 32'h0000_1004, 32'h1234_5678, 32'hCAFE_F00D, 0, 0, 1'b0, 4};
    vecs[2] = '{32'h0000_2000, 1'b0, 32'h0, 32'h0, 32'hA5A5_A5A5, 0, 3, 1'b0, 6};
    vecs[3] = '{32'h0000_3003, 1'b1, 32'h0000_1006, 32'hFFFF_0000, 32'h0BAD_F00D, 2, 1, 1'b0, 7};
    vecs[4] = '{32'h0000_0040, 1'b1, 32'h0000_0080, 32'h1111_1111, 32'h2222_2222, 0, 0, 1'b1, 4};
    vecs[5] = '{32'hFFFF_FFFE, 1'b0, 32'h0, 32'h0, 32'h1357_9BDF, 1, 0, 1'b1, 3};

    // reset values, before any clock edge
    #2;
    check("rst_stall", stall, 1'b0);
    check("rst_ram_req", ram_req, 1'b0);
    check("rst_after_miss", after_miss, 1'b0);
    @(negedge clk);
    check("rst_state", state_dbg, 2'd0);
    check("rst_ram_addr", ram_addr, 32'h0);
    check("rst_ram_wd", ram_wd, 32'h0);
    check("rst_rd_from_ram", rd_from_ram, 32'h0);
    rst = 1'b0;
    idle(3);

    // abort: reset in the middle of a writeback
    en = 1'b1; cache_miss = 1'b1; evict_we = 1'b1;
    addr = 32'h0000_0500; evict_addr = 32'h0000_0600; evict_data = 32'h0000_0077;
    @(negedge clk);
    en = 1'b0; cache_miss = 1'b0;
    #1;
    check("abort_wb_req", ram_req, 1'b1);
    check("abort_wb_we", ram_we, 1'b1);
    check("abort_wb_addr", ram_addr, 32'h0000_0600);
    #2 rst = 1'b1;
    #1;
    check("abort_ram_req", ram_req, 1'b0);
    check("abort_stall", stall, 1'b0);
    check("abort_after_miss", after_miss, 1'b0);
    check("abort_ram_we", ram_we, 1'b0);
    model_miss = 0; model_wb = 0; last_rd = '0;
    @(negedge clk);
    rst = 1'b0;
    idle(4);

    // table-driven misses
    foreach (vecs[i]) begin
      if (!vecs[i].b2b) idle(2);
      run_miss(vecs[i]);
    end
    idle(2);
`ifdef PERF_COUNTERS_EN
    check("miss_count_mid", miss_count, sat(model_miss));
    check("wb_count_mid", wb_count, sat(model_wb));
`endif

    // 17 dirty misses back to back drive the counters into saturation
    for (int k = 0; k < 17; k++) begin
      v = '{$urandom(), 1'b1, $urandom(), $urandom(), $urandom(), 0, 0, 1'b1, 4};
      run_miss(v);
    end
    idle(2);
`ifdef PERF_COUNTERS_EN
    check("miss_count_sat", miss_count, sat(model_miss));
    check("wb_count_sat", wb_count, sat(model_wb));
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
